// File: rtl/intc_pkg.sv
// Shared types and constants for the priority interrupt controller.
// Holds the FSM state enum, control-field layout and cfg address decode.
package intc_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    // Control register layout: level in the low bits, enable just above.
    localparam int CTRL_LVL_LSB = 0;

    // cfg_addr MSB decode.
    localparam logic CFG_SEL_VEC  = 1'b0;
    localparam logic CFG_SEL_CTRL = 1'b1;

    function automatic int ctrl_en_bit(input int lvl_w);
        return CTRL_LVL_LSB + lvl_w;
    endfunction

endpackage

// File: rtl/intc_arbiter.sv
// Combinational priority arbiter: highest level wins, ties to lowest index.
// Ports: pending, levels, cur_lvl, in_service in; valid, win_id, win_lvl out.
module intc_arbiter #(
    parameter  int NUM_IRQ = 4,
    parameter  int LVL_W   = 2,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic [NUM_IRQ-1:0]            pending,
    input  logic [NUM_IRQ-1:0][LVL_W-1:0] levels,
    input  logic [LVL_W-1:0]              cur_lvl,
    input  logic                          in_service,
    output logic                          valid,
    output logic [ID_W-1:0]               win_id,
    output logic [LVL_W-1:0]              win_lvl
);

    always_comb begin
        valid   = 1'b0;
        win_id  = '0;
        win_lvl = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            // Only strictly higher levels may preempt an active handler.
            if (pending[i] && (!in_service || levels[i] > cur_lvl)) begin
                // Strict compare keeps the lower index on a tie.
                if (!valid || levels[i] > win_lvl) begin
                    valid   = 1'b1;
                    win_id  = ID_W'(i);
                    win_lvl = levels[i];
                end
            end
        end
    end

endmodule

// File: rtl/intc_prio.sv
// Nesting priority interrupt controller with vector/level/enable registers.
// Ports: CLK, Reset, irq, cfg_* bus, intr/int_vector/int_id/int_ack, int_ret,
// in_service, cur_lvl.
module intc_prio
    import intc_pkg::*;
#(
    parameter  int NUM_IRQ = 4,
    parameter  int DATA_W  = 16,
    parameter  int LVL_W   = 2,
    localparam int ID_W    = $clog2(NUM_IRQ)
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic              cfg_write,
    input  logic [ID_W:0]     cfg_addr,
    input  logic [DATA_W-1:0] cfg_data_in,
    output logic [DATA_W-1:0] cfg_data_out,
    output logic              intr,
    output logic [DATA_W-1:0] int_vector,
    output logic [ID_W-1:0]   int_id,
    input  logic              int_ack,
    input  logic              int_ret,
    output logic              in_service,
    output logic [LVL_W-1:0]  cur_lvl
);

    localparam int             EN_BIT  = ctrl_en_bit(LVL_W);
    localparam int             DEPTH   = 1 << LVL_W;
    localparam logic [LVL_W:0] SP_ONE  = (LVL_W+1)'(1);
    localparam logic [LVL_W:0] SP_FULL = (LVL_W+1)'(DEPTH);

    logic [DATA_W-1:0]             vec [NUM_IRQ];
    logic [NUM_IRQ-1:0][LVL_W-1:0] lvl;
    logic [NUM_IRQ-1:0]            en;
    logic [NUM_IRQ-1:0]            pending;
    logic [NUM_IRQ-1:0]            pend_next;
    logic [NUM_IRQ-1:0]            irq_q;

    state_t           state;
    logic [LVL_W-1:0] grant_lvl;
    logic [LVL_W-1:0] stack [DEPTH];
    logic [LVL_W:0]   sp;
    logic [LVL_W-1:0] top_idx;

    logic [ID_W-1:0]  ch;
    logic             ch_ok;
    logic             arb_valid;
    logic [ID_W-1:0]  arb_id;
    logic [LVL_W-1:0] arb_lvl;

    assign ch = cfg_addr[ID_W-1:0];

    // Address slots beyond NUM_IRQ exist only for non-power-of-2 counts.
    if ((1 << ID_W) == NUM_IRQ) begin : g_full
        assign ch_ok = 1'b1;
    end else begin : g_part
        assign ch_ok = ({1'b0, ch} < (ID_W+1)'(NUM_IRQ));
    end

    assign in_service = (sp != '0);
    assign top_idx    = sp[LVL_W-1:0] - LVL_W'(1);
    assign cur_lvl    = in_service ? stack[top_idx] : '0;

    always_comb begin
        cfg_data_out = '0;
        if (ch_ok) begin
            if (cfg_addr[ID_W] == CFG_SEL_CTRL) begin
                cfg_data_out[CTRL_LVL_LSB +: LVL_W] = lvl[ch];
                cfg_data_out[EN_BIT]                = en[ch];
            end else begin
                cfg_data_out = vec[ch];
            end
        end
    end

    // Ack clears first so that a same-cycle edge on that channel survives;
    // a disabling write has the final say.
    always_comb begin
        pend_next = pending;
        if (state == ST_REQ && int_ack)
            pend_next[int_id] = 1'b0;
        pend_next = pend_next | (irq & ~irq_q & en);
        if (cfg_write && ch_ok && cfg_addr[ID_W] == CFG_SEL_CTRL
            && !cfg_data_in[EN_BIT])
            pend_next[ch] = 1'b0;
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_IRQ; i++)
                vec[i] <= '0;
            lvl     <= '0;
            en      <= '0;
            pending <= '0;
            irq_q   <= '0;
        end else begin
            irq_q   <= irq;
            pending <= pend_next;
            if (cfg_write && ch_ok) begin
                if (cfg_addr[ID_W] == CFG_SEL_CTRL) begin
                    lvl[ch] <= cfg_data_in[CTRL_LVL_LSB +: LVL_W];
                    en[ch]  <= cfg_data_in[EN_BIT];
                end else begin
                    vec[ch] <= cfg_data_in;
                end
            end
        end
    end

    intc_arbiter #(
        .NUM_IRQ (NUM_IRQ),
        .LVL_W   (LVL_W)
    ) u_arb (
        .pending    (pending),
        .levels     (lvl),
        .cur_lvl    (cur_lvl),
        .in_service (in_service),
        .valid      (arb_valid),
        .win_id     (arb_id),
        .win_lvl    (arb_lvl)
    );

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state      <= ST_IDLE;
            intr       <= 1'b0;
            int_vector <= '0;
            int_id     <= '0;
            grant_lvl  <= '0;
            sp         <= '0;
            for (int i = 0; i < DEPTH; i++)
                stack[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (int_ret && in_service)
                        sp <= sp - SP_ONE;
                    if (arb_valid) begin
                        state      <= ST_REQ;
                        intr       <= 1'b1;
                        int_id     <= arb_id;
                        int_vector <= vec[arb_id];
                        grant_lvl  <= arb_lvl;
                    end
                end
                ST_REQ: begin
                    if (int_ack) begin
                        state <= ST_IDLE;
                        intr  <= 1'b0;
                        if (sp != SP_FULL) begin
                            stack[sp[LVL_W-1:0]] <= grant_lvl;
                            sp <= sp + SP_ONE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_intc_prio.sv
// Directed testbench for intc_prio: cfg readback table plus nesting,
// tie-break, blocking, collision, disable and reset sequences.
module tb_intc_prio;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [3:0]  irq;
    logic        cfg_write;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data_in;
    logic [15:0] cfg_data_out;
    logic        intr;
    logic [15:0] int_vector;
    logic [1:0]  int_id;
    logic        int_ack;
    logic        int_ret;
    logic        in_service;
    logic [1:0]  cur_lvl;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
        logic [15:0] exp;
    } cfg_vec_t;

    cfg_vec_t tbl [8];

    always #5 CLK = ~CLK;

    intc_prio #(
        .NUM_IRQ (4),
        .DATA_W  (16),
        .LVL_W   (2)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .irq          (irq),
        .cfg_write    (cfg_write),
        .cfg_addr     (cfg_addr),
        .cfg_data_in  (cfg_data_in),
        .cfg_data_out (cfg_data_out),
        .intr         (intr),
        .int_vector   (int_vector),
        .int_id       (int_id),
        .int_ack      (int_ack),
        .int_ret      (int_ret),
        .in_service   (in_service),
        .cur_lvl      (cur_lvl)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic cfg_wr(input logic [2:0] a, input logic [15:0] d);
        cfg_write   = 1'b1;
        cfg_addr    = a;
        cfg_data_in = d;
        tick();
        cfg_write   = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [15:0] d);
        cfg_addr = a;
        #1;
        d = cfg_data_out;
    endtask

    // Edge then two ticks: a granted request is visible on return.
    task automatic pulse(input logic [3:0] m);
        irq = m;
        tick();
        irq = 4'b0;
        tick();
    endtask

    task automatic ack();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
    endtask

    task automatic ret();
        int_ret = 1'b1;
        tick();
        int_ret = 1'b0;
    endtask

    initial begin
        logic [15:0] d;

        tbl[0] = '{3'b000, 16'h1000, 16'h1000};
        tbl[1] = '{3'b001, 16'h2000, 16'h2000};
        tbl[2] = '{3'b010, 16'h0040, 16'h0040};
        tbl[3] = '{3'b011, 16'h3000, 16'h3000};
        tbl[4] = '{3'b100, 16'hFFF6, 16'h0006};
        tbl[5] = '{3'b101, 16'h0007, 16'h0007};
        tbl[6] = '{3'b110, 16'h0005, 16'h0005};
        tbl[7] = '{3'b111, 16'h0006, 16'h0006};

        Reset       = 1'b1;
        irq         = '0;
        cfg_write   = 1'b0;
        cfg_addr    = '0;
        cfg_data_in = '0;
        int_ack     = 1'b0;
        int_ret     = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        tick();

        chk("rst_intr", intr, 0);
        chk("rst_vec", int_vector, 0);
        chk("rst_id", int_id, 0);
        chk("rst_insvc", in_service, 0);
        chk("rst_lvl", cur_lvl, 0);
        rd(3'b101, d);
        chk("rst_ctrl1", d, 0);
        rd(3'b001, d);
        chk("rst_vec1", d, 0);

        for (int i = 0; i < 8; i++) begin
            cfg_wr(tbl[i].addr, tbl[i].data);
            rd(tbl[i].addr, d);
            chk($sformatf("cfg_rb%0d", i), d, tbl[i].exp);
        end

        // Basic grant with 2-cycle latency, then nesting.
        irq = 4'b0100;
        tick();
        chk("a_lat", intr, 0);
        irq = 4'b0000;
        tick();
        chk("a_intr", intr, 1);
        chk("a_vec", int_vector, 16'h0040);
        chk("a_id", int_id, 2);
        ack();
        chk("a_ackintr", intr, 0);
        chk("a_insvc", in_service, 1);
        chk("a_lvl", cur_lvl, 1);
        pulse(4'b1000);
        chk("a_nest_intr", intr, 1);
        chk("a_nest_id", int_id, 3);
        chk("a_nest_vec", int_vector, 16'h3000);
        ret();
        chk("a_retreq_intr", intr, 1);
        chk("a_retreq_lvl", cur_lvl, 1);
        ack();
        chk("a_nest_lvl", cur_lvl, 2);
        ret();
        chk("a_ret1", cur_lvl, 1);
        ret();
        chk("a_ret2", cur_lvl, 0);
        chk("a_ret2_svc", in_service, 0);
        ret();
        chk("a_ret3", cur_lvl, 0);
        chk("a_ret3_svc", in_service, 0);

        // Ack while idle is ignored.
        ack();
        chk("idle_ack_svc", in_service, 0);

        // Tie at level 2: channel 0 before channel 3.
        pulse(4'b1001);
        chk("b_intr", intr, 1);
        chk("b_id0", int_id, 0);
        chk("b_vec0", int_vector, 16'h1000);
        ack();
        chk("b_lvl", cur_lvl, 2);
        tick();
        tick();
        chk("b_block", intr, 0);
        ret();
        chk("b_ret_lat", intr, 0);
        tick();
        chk("b_intr3", intr, 1);
        chk("b_id3", int_id, 3);
        ack();
        ret();

        // Level-3 handler blocks a level-1 edge until return.
        cfg_wr(3'b100, 16'h0005);
        pulse(4'b0010);
        chk("c_id1", int_id, 1);
        ack();
        chk("c_lvl3", cur_lvl, 3);
        pulse(4'b0001);
        tick();
        chk("c_block", intr, 0);
        ret();
        chk("c_ret_lvl", cur_lvl, 0);
        chk("c_ret_lat", intr, 0);
        tick();
        chk("c_intr0", intr, 1);
        chk("c_id0", int_id, 0);
        ack();
        ret();

        // New edge in the ack cycle keeps the channel pending.
        pulse(4'b0100);
        chk("d_intr", intr, 1);
        irq     = 4'b0100;
        int_ack = 1'b1;
        tick();
        irq     = 4'b0000;
        int_ack = 1'b0;
        chk("d_ack_intr", intr, 0);
        tick();
        chk("d_block", intr, 0);
        ret();
        tick();
        chk("d_reintr", intr, 1);
        chk("d_id2", int_id, 2);
        ack();
        ret();

        // Disabled channel edges are lost; enable alone does not request.
        cfg_wr(3'b111, 16'h0002);
        pulse(4'b1000);
        tick();
        chk("e_dis", intr, 0);
        cfg_wr(3'b111, 16'h0006);
        tick();
        tick();
        chk("e_en_only", intr, 0);
        pulse(4'b1000);
        chk("e_intr", intr, 1);
        cfg_wr(3'b011, 16'hBEEF);
        chk("e_vec_held", int_vector, 16'h3000);
        chk("e_intr_held", intr, 1);
        ack();
        ret();

        // Reset mid-request with two levels stacked.
        pulse(4'b0100);
        ack();
        pulse(4'b1000);
        chk("f_vec3", int_vector, 16'hBEEF);
        ack();
        chk("f_lvl2", cur_lvl, 2);
        pulse(4'b0010);
        chk("f_intr", intr, 1);
        Reset = 1'b1;
        #1;
        chk("f_rst_intr", intr, 0);
        chk("f_rst_vec", int_vector, 0);
        chk("f_rst_id", int_id, 0);
        chk("f_rst_svc", in_service, 0);
        chk("f_rst_lvl", cur_lvl, 0);
        tick();
        Reset = 1'b0;
        tick();
        rd(3'b101, d);
        chk("f_ctrl1", d, 0);
        pulse(4'b0010);
        tick();
        chk("f_noreq", intr, 0);
        cfg_wr(3'b101, 16'h0007);
        pulse(4'b0010);
        chk("f_req", intr, 1);
        chk("f_req_id", int_id, 1);
        chk("f_req_vec", int_vector, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intc_prio.md
# intc_prio

Parametrised, nesting-capable interrupt controller; successor to the fixed two-line, two-level interrupt logic in `datapath`. It sits between the external interrupt sources and the 16-bit CPU control unit. It latches rising edges on `NUM_IRQ` lines and arbitrates by programmable per-channel priority, then presents the winning channel's handler vector with an `intr`/`int_ack` handshake. It tracks nested service levels so that only strictly higher-priority interrupts preempt a running handler.

## Interface
- `NUM_IRQ`, 4: number of interrupt lines; legal range 2..8.
- `DATA_W`, 16: vector and configuration data width.
- `LVL_W`, 2: priority field width; levels 0..2^LVL_W-1, higher value wins.
- `CLK`  in  1  single system clock; all state updates on its rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `irq`  in  NUM_IRQ  interrupt sources, synchronous to `CLK`, rising-edge sensitive.
- `cfg_write`  in  1  write strobe for the configuration register addressed by `cfg_addr`.
- `cfg_addr`  in  clog2(NUM_IRQ)+1  low bits select the channel; MSB=0 selects the vector register, MSB=1 selects the control register.
- `cfg_data_in`  in  DATA_W  write data. In a control write, bits [LVL_W-1:0] are the level and bit LVL_W is the enable.
- `cfg_data_out`  out  DATA_W  combinational readback of the addressed register; unused control bits read 0.
- `intr`  out  1  interrupt request to the CPU.
- `int_vector`  out  DATA_W  handler address of the granted channel; stable while `intr`=1.
- `int_id`  out  clog2(NUM_IRQ)  index of the granted channel.
- `int_ack`  in  1  CPU accepts the request (one-cycle pulse).
- `int_ret`  in  1  CPU returns from the current handler (one-cycle pulse).
- `in_service`  out  1  at least one handler is active.
- `cur_lvl`  out  LVL_W  level of the innermost active handler; 0 when `in_service`=0.

## Operation
- Edge detect: a registered copy of `irq` is kept. A channel's `pending` bit is set when `irq[i]` & ~prev[i] & enable[i].
- Enable: writing enable=0 clears that channel's pending bit.
- Set/clear collision: a new edge in the same cycle as an ack of that channel leaves `pending`=1.
- Arbitration (combinational): among pending channels, the highest level wins; a tie goes to the lowest index.
  - A candidate is eligible only if `in_service`=0 or its level > `cur_lvl`.
- FSM states:
  - IDLE: `intr`=0. If an eligible candidate exists, latch `int_id`, `int_vector` and the winner's level, then go to REQ.
  - REQ: `intr`=1. The latched winner is held even if a higher-priority channel becomes pending; there is no re-arbitration before ack.
  - REQ on `int_ack`: clear the granted channel's pending bit, push the level onto the service stack, go to IDLE.
  - A configuration write to the latched channel during REQ does not alter the latched vector or level.
- Service stack: depth 2^LVL_W.
  - `int_ret` in IDLE pops the stack.
  - `int_ret` in REQ is ignored.
  - `int_ret` with an empty stack is ignored.
  - `int_ack` in IDLE is ignored.
- Reset (any time, including mid-REQ or mid-nesting): pending=0, prev irq=0, all vector and control registers=0 (disabled, level 0), stack empty, FSM=IDLE, `intr`=0, `int_vector`=0, `int_id`=0, `in_service`=0, `cur_lvl`=0.

## Timing
- `irq[i]` sampled high at edge N (low at N-1): pending set at N; FSM enters REQ at N+1; `intr` high after N+1. Edge-to-request latency is 2 cycles.
- `int_ack` sampled at edge M: `intr` low after M; `cur_lvl` and `in_service` updated after M.
- The next request can assert `intr` after M+1, so there is at least one low cycle between grants.
- `int_ret` sampled at edge R: `cur_lvl` drops after R. A waiting lower-priority channel raises `intr` after R+1.
- A configuration write takes effect at the writing edge. A level change alters arbitration in the following cycle.

## Structure
- Package `intc_pkg`:
  - FSM state enum (IDLE, REQ).
  - Control field positions (level LSB, enable bit).
  - The `cfg_addr` MSB decode constant.
- Sub-module `intc_arbiter`: purely combinational. Inputs are the pending vector, the per-channel levels, `cur_lvl` and `in_service`. Outputs are `valid`, winner index and winner level.
- The top level holds the registers, edge detect, FSM and stack.

## Test plan
- Channel 2 enabled with level 1 and vector 0x0040. Pulse `irq[2]` -> `intr` high 2 cycles later with `int_vector`=0x0040, `int_id`=2. Ack -> `in_service`=1, `cur_lvl`=1.
- Channels 0 and 3 both at level 2, both edge in the same cycle -> `int_id`=0 granted first. After ack and `int_ret`, channel 3 granted.
- Channel 1 running at level 3; a channel 0 level-1 edge arrives -> no `intr`. `int_ret` -> `intr` for channel 0 two cycles later.
- Nesting: level 1 handler active, level 2 channel edges -> `intr`, ack -> `cur_lvl`=2. Two `int_ret` -> `cur_lvl`=0. A third `int_ret` -> no change.
- Disabled channel edge -> no pending. Enable-write afterwards -> still no request until the next edge.
- `Reset` asserted while `intr`=1 and the stack holds 2 levels -> all outputs 0 immediately. No request after release until a new edge on a channel re-enabled after reset.
